// File: rtl/jtframe_sdram_rrarb_if.sv
// jtframe_sdram_rrarb_if: requester and SDRAM-controller handshake bundle for the round-robin scheduler
// Signals:
//   req/rnw/addr/din/wrmask  - packed per-requester request fields (driven by requesters)
//   gnt/done                 - per-requester grant and completion pulse (driven by scheduler)
//   sdram_rd/sdram_wr/sdram_addr/data_write/sdram_wrmask - command to the controller
//   sdram_ack/data_rdy       - controller accept and completion
//   timeout_err              - sticky watchdog flag
interface jtframe_sdram_rrarb_if #(
    parameter int N      = 4,
    parameter int SDRAMW = 22
);
    logic [N-1:0]        req;
    logic [N-1:0]        rnw;
    logic [N*SDRAMW-1:0] addr;
    logic [N*16-1:0]     din;
    logic [N*2-1:0]      wrmask;
    logic [N-1:0]        gnt;
    logic [N-1:0]        done;
    logic                sdram_rd;
    logic                sdram_wr;
    logic [SDRAMW-1:0]   sdram_addr;
    logic [15:0]         data_write;
    logic [1:0]          sdram_wrmask;
    logic                sdram_ack;
    logic                data_rdy;
    logic                timeout_err;
    modport slave (
        input  req, rnw, addr, din, wrmask, sdram_ack, data_rdy,
        output gnt, done, sdram_rd, sdram_wr, sdram_addr, data_write, sdram_wrmask, timeout_err
    );
    modport master (
        output req, rnw, addr, din, wrmask, sdram_ack, data_rdy,
        input  gnt, done, sdram_rd, sdram_wr, sdram_addr, data_write, sdram_wrmask, timeout_err
    );
endinterface

// File: rtl/jtframe_sdram_rrarb.sv
// jtframe_sdram_rrarb: round-robin SDRAM access scheduler with write precedence, read-starvation guard and watchdog
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active-high
//   bus  - slave side of jtframe_sdram_rrarb_if: requests in, gnt/done out,
//          registered SDRAM command out, sdram_ack/data_rdy in, sticky timeout_err out
module jtframe_sdram_rrarb #(
    parameter int N      = 4,
    parameter int SDRAMW = 22,
    parameter int WRPRIO = 1,
    parameter int STARVE = 4,
    parameter int TOUT   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    jtframe_sdram_rrarb_if.slave  bus
);
    localparam int PW = $clog2(N);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d, win;
    logic [PW:0]       sum;
    logic [3:0]        skip_q, skip_d;
    logic [9:0]        wd_q, wd_d;
    logic [N-1:0]      gnt_q, gnt_d, elig, wr_elig, cand, rot;
    logic              rd_q, rd_d, wr_q, wr_d, terr_q, terr_d;
    logic [SDRAMW-1:0] addr_q, addr_d;
    logic [15:0]       dw_q, dw_d;
    logic [1:0]        mask_q, mask_d;
    logic              busy, complete, tout, restrict_w, hit, arb, win_rd, drop_cmd;
    // The requester finishing this cycle is excluded so it cannot be re-granted back to back.
    assign elig       = bus.req & ~gnt_q;
    assign wr_elig    = elig & ~bus.rnw;
    assign restrict_w = (WRPRIO != 0) && (|wr_elig) && (skip_q < 4'(STARVE));
    assign cand       = restrict_w ? wr_elig : elig;
    assign busy       = state_q != IDLE;
    assign complete   = busy & bus.data_rdy;
    assign tout       = busy & ~bus.data_rdy & (wd_q == 10'(TOUT - 1));
    assign drop_cmd   = complete | tout | (state_q == ISSUE & bus.sdram_ack);
    // Rotate candidates so bit 0 is the requester at ptr; lowest set bit is the winner.
    always_comb begin
        rot = N'({cand, cand} >> ptr_q);
        hit = |rot;
        sum = '0;
        for (int k = N - 1; k >= 0; k--)
            if (rot[k]) sum = {1'b0, ptr_q} + (PW+1)'(k);
        win = sum >= (PW+1)'(N) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
    end
    assign win_rd = bus.rnw[win];
    assign arb    = hit & (~busy | complete);
    always_ff @(posedge clk)
        state_q <= rst ? IDLE : state_d;
    always_comb
        state_d = arb ? ISSUE : (complete | tout) ? IDLE : (state_q == ISSUE & bus.sdram_ack) ? WAIT : state_q;
    always_comb begin
        gnt_d  = arb ? N'(1) << win : (complete | tout) ? '0 : gnt_q;
        rd_d   = arb ? win_rd : drop_cmd ? 1'b0 : rd_q;
        wr_d   = arb ? ~win_rd : drop_cmd ? 1'b0 : wr_q;
        addr_d = arb ? bus.addr[win*SDRAMW +: SDRAMW] : addr_q;
        dw_d   = arb ? bus.din[win*16 +: 16] : dw_q;
        mask_d = arb ? (win_rd ? 2'b11 : bus.wrmask[win*2 +: 2]) : mask_q;
        ptr_d  = arb ? (win == PW'(N - 1) ? '0 : win + PW'(1)) : ptr_q;
        // A read counts as skipped whenever a write is chosen by the restricted search while any read is eligible.
        skip_d = !arb ? skip_q : win_rd ? 4'd0 : (restrict_w & |(elig & bus.rnw)) ? skip_q + 4'd1 : skip_q;
        wd_d   = (arb | tout) ? 10'd0 : busy ? wd_q + 10'd1 : wd_q;
        terr_d = terr_q | tout;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q  <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            dw_q   <= '0;
            mask_q <= 2'b11;
            ptr_q  <= '0;
            skip_q <= '0;
            wd_q   <= '0;
            terr_q <= 1'b0;
        end else begin
            gnt_q  <= gnt_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            addr_q <= addr_d;
            dw_q   <= dw_d;
            mask_q <= mask_d;
            ptr_q  <= ptr_d;
            skip_q <= skip_d;
            wd_q   <= wd_d;
            terr_q <= terr_d;
        end
    end
    assign bus.gnt          = gnt_q;
    assign bus.done         = gnt_q & {N{bus.data_rdy}};
    assign bus.sdram_rd     = rd_q;
    assign bus.sdram_wr     = wr_q;
    assign bus.sdram_addr   = addr_q;
    assign bus.data_write   = dw_q;
    assign bus.sdram_wrmask = mask_q;
    assign bus.timeout_err  = terr_q;
endmodule
